// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to uart_tx/uart_rx plus
// frame-format constants.
package uart_pkg;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_IDLE  = 4'd1,
        ST_START = 4'd2,
        ST_DATA  = 4'd3,
        ST_STOP  = 4'd4,
        ST_BREAK = 4'd5
    } uart_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic [31:0] MIN_PERIOD = 32'd4;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchronizer for an asynchronous input with falling-edge detect.
// Stages reset to 1 so an idle-high line never produces a spurious edge.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] stages_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stages_q <= '1;
            prev_q   <= 1'b1;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], async_i};
            prev_q   <= stages_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stages_q[SYNC_STAGES-1];
    assign fall_o = ~stages_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, one-cycle pulses
// for a good byte (out_sync) or a low stop bit (frame_err).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] period,
    input  logic        rx,
    output logic        out_sync,
    output logic [7:0]  out_data,
    output logic        frame_err,
    output logic        busy
);

    uart_state_e          state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          per_q, per_d;
    logic [31:0]          half_q, half_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 sync_q, sync_d;
    logic                 err_q, err_d;
    logic                 rx_s;
    logic                 rx_fall;

    uart_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .async_i(rx),
        .sync_o (rx_s),
        .fall_o (rx_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            half_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            sync_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            half_q    <= half_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            sync_q    <= sync_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        half_d    = half_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        sync_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Period is captured here so later changes cannot disturb a frame.
                if (rx_fall && period >= MIN_PERIOD) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                    per_d   = period;
                    half_d  = period >> 1;
                end
            end
            ST_START: begin
                if (cnt_q == half_q - 32'd1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == per_q - 32'd1) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == per_q - 32'd1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        sync_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_BREAK: begin
                // A held-low line must return high before a new start is allowed.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_sync  = sync_q;
    assign frame_err = err_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level event scoreboard predicts
// when each pulse must appear and which byte it carries.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] period = 32'd16;
    logic        rx = 1'b1;
    logic        out_sync;
    logic [7:0]  out_data;
    logic        frame_err;
    logic        busy;

    uart_rx #(
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .period   (period),
        .rx       (rx),
        .out_sync (out_sync),
        .out_data (out_data),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int unsigned n = 0;
    always @(posedge clk) n <= n + 1;

    typedef struct {
        int unsigned cyc;
        bit          ok;
        logic [7:0]  data;
    } evt_t;

    evt_t        evq[$];
    logic [7:0]  m_data = 8'h00;
    int unsigned rst_at = 1;
    int          vecs = 0;
    int          errs = 0;
    int unsigned last_sync = 0;
    int unsigned n_sync = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    // Per-cycle comparison against the frame-level scoreboard.
    always @(negedge clk) begin
        bit exp_sync;
        bit exp_err;
        if (n >= 1) begin
            if (n == rst_at) begin
                m_data = 8'h00;
                evq.delete();
            end
            exp_sync = 1'b0;
            exp_err  = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == n) begin
                if (evq[0].ok) begin
                    exp_sync = 1'b1;
                    m_data   = evq[0].data;
                end else begin
                    exp_err = 1'b1;
                end
                void'(evq.pop_front());
            end
            check("out_sync", 32'(out_sync), 32'(exp_sync));
            check("frame_err", 32'(frame_err), 32'(exp_err));
            check("out_data", 32'(out_data), 32'(m_data));
            if (out_sync) begin
                last_sync = n;
                n_sync++;
            end
            if (frame_err) n_err++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Line-side transmitter; a frame whose start edge is taken at cycle c
    // produces its pulse SYNC_STAGES+1 cycles later plus half a bit plus 9 bits.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int unsigned bl,
                              input bit expect_evt, output int unsigned c);
        evt_t e;
        rx = 1'b0;
        c  = n;
        if (expect_evt) begin
            e.cyc  = c + 3 + (bl >> 1) + 9 * bl;
            e.ok   = stop;
            e.data = d;
            evq.push_back(e);
        end
        repeat (bl) step();
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bl) step();
        end
        rx = stop;
        repeat (bl) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned c;
        int unsigned first;
        int unsigned base_sync;

        step(); step(); step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_sync", 32'(out_sync), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset out_data", 32'(out_data), 32'h00);
        rst = 1'b1;
        repeat (20) step();

        // Single 0xA5 frame, period 16.
        send_frame(8'hA5, 1'b1, 16, 1'b1, c);
        repeat (4) step();
        check("a5 pulse cycle", last_sync, c + 155);
        check("a5 data", 32'(out_data), 32'hA5);
        check("a5 pulse count", n_sync, 1);
        check("a5 no frame_err", n_err, 0);

        // Back-to-back 0x00 / 0xFF, no idle gap.
        send_frame(8'h00, 1'b1, 16, 1'b1, c);
        first = last_sync;
        check("b2b first data", 32'(out_data), 32'h00);
        send_frame(8'hFF, 1'b1, 16, 1'b1, c);
        repeat (4) step();
        check("b2b spacing", last_sync - first, 160);
        check("b2b second data", 32'(out_data), 32'hFF);
        check("b2b pulse count", n_sync, 3);

        // 3-cycle glitch: START is abandoned at the mid-start sample.
        rx = 1'b0;
        c  = n;
        repeat (3) step();
        rx = 1'b1;
        repeat (7) step();
        check("glitch busy before sample", 32'(busy), 32'd1);
        step();
        check("glitch busy after sample", 32'(busy), 32'd0);
        repeat (40) step();
        check("glitch no pulse", n_sync, 3);
        check("glitch no err", n_err, 0);

        // 0x3C with low stop bit, then line held low (break).
        send_frame(8'h3C, 1'b0, 16, 1'b1, c);
        repeat (200) step();
        check("break busy", 32'(busy), 32'd1);
        check("break err count", n_err, 1);
        check("break data kept", 32'(out_data), 32'hFF);
        repeat (200) step();
        rx = 1'b1;
        repeat (5) step();
        check("break released", 32'(busy), 32'd0);
        check("break no retrigger", n_sync, 3);

        // Reset mid-DATA of 0x55, then clean 0x81.
        rx = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (16) step();
        end
        rx     = 1'b1;
        rst    = 1'b0;
        rst_at = n + 1;
        step();
        rst = 1'b1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset out_sync", 32'(out_sync), 32'd0);
        check("midreset frame_err", 32'(frame_err), 32'd0);
        check("midreset out_data", 32'(out_data), 32'h00);
        repeat (30) step();
        send_frame(8'h81, 1'b1, 16, 1'b1, c);
        repeat (4) step();
        check("81 pulse cycle", last_sync, c + 155);
        check("81 data", 32'(out_data), 32'h81);

        // period=4 frames; period changed to 20 mid-frame has no effect.
        base_sync = n_sync;
        period = 32'd4;
        send_frame(8'h96, 1'b1, 4, 1'b1, c);
        fork
            send_frame(8'h69, 1'b1, 4, 1'b1, c);
            begin
                repeat (10) step();
                period = 32'd20;
            end
        join
        repeat (4) step();
        check("p4 pulse count", n_sync, base_sync + 2);
        check("p4 last data", 32'(out_data), 32'h69);

        // period=3 at the edge: ignored entirely.
        period = 32'd3;
        fork
            send_frame(8'h00, 1'b1, 3, 1'b0, c);
            begin
                repeat (6) step();
                check("p3 busy early", 32'(busy), 32'd0);
                repeat (10) step();
                check("p3 busy late", 32'(busy), 32'd0);
            end
        join
        repeat (10) step();
        check("p3 no pulse", n_sync, base_sync + 2);

        period = 32'd16;
        repeat (20) step();
        send_frame(8'hC3, 1'b1, 16, 1'b1, c);
        repeat (4) step();
        check("c3 data", 32'(out_data), 32'hC3);
        check("scoreboard drained", evq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
